uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver top. Captures each

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receive buffer and its neighbours: frame capture
// inputs from the receiver, FWFT read port and status outputs toward the host.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      rx_data;
    logic [2:0]      rx_error;
    logic            rx_done;
    logic            rd_en;
    logic            clr_overrun;

    logic            rd_valid;
    logic [7:0]      rd_data;
    logic [2:0]      rd_error;
    logic [ADDR_W:0] count;
    logic            full;
    logic            empty;
    logic            overrun;
    logic [7:0]      err_cnt;

    // master drives frames and read requests; slave is the buffer itself
    modport master (
        output rx_data, rx_error, rx_done, rd_en, clr_overrun,
        input  rd_valid, rd_data, rd_error, count, full, empty, overrun, err_cnt
    );

    modport slave (
        input  rx_data, rx_error, rx_done, rd_en, clr_overrun,
        output rd_valid, rd_data, rd_error, count, full, empty, overrun, err_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one frame per rising edge of the receiver done
// flag into a first-word-fall-through FIFO, with overrun and error-frame tracking.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DROP_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_rx_fifo_if.slave    bus
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      ERR_MAX    = 8'hFF;
    localparam bit              DROP_EN    = (DROP_ERR != 0);

    // each entry is {error flags, data byte}
    logic [10:0]       mem_q [DEPTH];

    logic              done_q, done_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              wr_req;
    logic              has_err;
    logic              store_cand;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic              full;
    logic              empty;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    always_comb begin
        wr_req     = 1'b0;
        has_err    = 1'b0;
        store_cand = 1'b0;
        pop        = 1'b0;
        wr_en      = 1'b0;
        drop       = 1'b0;
        done_d     = bus.rx_done;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        err_cnt_d  = err_cnt_q;

        wr_req     = bus.rx_done & ~done_q;
        has_err    = (bus.rx_error != 3'b000);
        store_cand = wr_req & ~(DROP_EN & has_err);
        pop        = bus.rd_en & ~empty;
        // a simultaneous pop frees the slot the new frame lands in
        wr_en      = store_cand & (~full | pop);
        drop       = store_cand & full & ~pop;

        if (wr_req && has_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // done_q resets high so a done level held through reset release is not a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.rx_error, bus.rx_data};
        end
    end

    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = mem_q[rd_ptr_q][7:0];
    assign bus.rd_error = mem_q[rd_ptr_q][10:8];
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overrun  = overrun_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one instance storing error frames, one
// dropping them, both fed the same frame and read stimulus.
module tb_uart_rx_fifo;

    logic clk;
    logic rst_n;

    int check_cnt = 0;
    int pass_cnt  = 0;

    uart_rx_fifo_if #(.ADDR_W(4)) bus0 ();
    uart_rx_fifo_if #(.ADDR_W(4)) bus1 ();

    assign bus1.rx_data     = bus0.rx_data;
    assign bus1.rx_error    = bus0.rx_error;
    assign bus1.rx_done     = bus0.rx_done;
    assign bus1.rd_en       = bus0.rd_en;
    assign bus1.clr_overrun = bus0.clr_overrun;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .DROP_ERR(0)) dut_keep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .DROP_ERR(1)) dut_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic done, input logic [7:0] data,
                                 input logic [2:0] err, input logic rd,
                                 input logic clr);
        bus0.rx_done     = done;
        bus0.rx_data     = data;
        bus0.rx_error    = err;
        bus0.rd_en       = rd;
        bus0.clr_overrun = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // one done pulse: rising edge captured on the first clock, low on the second
    task automatic sendFrame(input logic [7:0] data, input logic [2:0] err,
                             input logic rd, input logic clr);
        applyStimulus(1'b1, data, err, rd, clr);
        tick();
        applyStimulus(1'b0, data, err, 1'b0, 1'b0);
        tick();
    endtask

    logic [7:0] model_q[$];
    logic       model_prev_done;
    logic       model_pop;
    logic       model_wr;
    logic       cyc_done;
    logic       cyc_rd;
    logic [7:0] next_byte;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_count",    32'(bus0.count),    32'd0);
        checkOutput("reset_empty",    32'(bus0.empty),    32'd1);
        checkOutput("reset_full",     32'(bus0.full),     32'd0);
        checkOutput("reset_rd_valid", 32'(bus0.rd_valid), 32'd0);
        checkOutput("reset_overrun",  32'(bus0.overrun),  32'd0);
        checkOutput("reset_err_cnt",  32'(bus0.err_cnt),  32'd0);

        // long done pulse yields exactly one entry
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 8'hA5, 3'b000, 1'b0, 1'b0);
        tick();
        checkOutput("single_count",    32'(bus0.count),    32'd1);
        checkOutput("single_rd_valid", 32'(bus0.rd_valid), 32'd1);
        checkOutput("single_rd_data",  32'(bus0.rd_data),  32'hA5);
        checkOutput("single_rd_error", 32'(bus0.rd_error), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("long_pulse_count", 32'(bus0.count), 32'd1);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("single_pop_empty", 32'(bus0.empty), 32'd1);
        tick();
        checkOutput("rd_empty_count",    32'(bus0.count),    32'd0);
        checkOutput("rd_empty_rd_valid", 32'(bus0.rd_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);

        // fill to capacity, then one frame too many
        for (int i = 0; i < 16; i++) sendFrame(8'(i), 3'b000, 1'b0, 1'b0);
        checkOutput("fill_full",    32'(bus0.full),    32'd1);
        checkOutput("fill_count",   32'(bus0.count),   32'd16);
        checkOutput("fill_overrun", 32'(bus0.overrun), 32'd0);
        sendFrame(8'h10, 3'b000, 1'b0, 1'b0);
        checkOutput("ovr_overrun", 32'(bus0.overrun), 32'd1);
        checkOutput("ovr_count",   32'(bus0.count),   32'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
            checkOutput($sformatf("drain_data_%0d", i), 32'(bus0.rd_data), 32'(i));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("drain_empty", 32'(bus0.empty), 32'd1);

        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("clr_overrun", 32'(bus0.overrun), 32'd0);

        // overrun set wins over a same-cycle clear
        for (int i = 0; i < 16; i++) sendFrame(8'(8'h20 + i), 3'b000, 1'b0, 1'b0);
        checkOutput("refill_full", 32'(bus0.full), 32'd1);
        sendFrame(8'h30, 3'b000, 1'b0, 1'b1);
        checkOutput("set_beats_clr", 32'(bus0.overrun), 32'd1);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("clr_after_set", 32'(bus0.overrun), 32'd0);

        // write into a full FIFO while popping
        applyStimulus(1'b1, 8'h31, 3'b000, 1'b1, 1'b0);
        checkOutput("full_pop_head", 32'(bus0.rd_data), 32'h20);
        tick();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("full_pop_count",   32'(bus0.count),   32'd16);
        checkOutput("full_pop_overrun", 32'(bus0.overrun), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
            checkOutput($sformatf("full_pop_data_%0d", i), 32'(bus0.rd_data),
                        (i < 15) ? 32'(8'h21 + i) : 32'h31);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("full_pop_empty", 32'(bus0.empty), 32'd1);

        // error frame stored in one instance, dropped in the other
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        sendFrame(8'h55, 3'b010, 1'b0, 1'b0);
        sendFrame(8'h3C, 3'b000, 1'b0, 1'b0);
        checkOutput("keep_err_cnt",  32'(bus0.err_cnt),  32'd1);
        checkOutput("keep_count",    32'(bus0.count),    32'd2);
        checkOutput("keep_rd_data",  32'(bus0.rd_data),  32'h55);
        checkOutput("keep_rd_error", 32'(bus0.rd_error), 32'b010);
        checkOutput("drop_err_cnt",  32'(bus1.err_cnt),  32'd1);
        checkOutput("drop_count",    32'(bus1.count),    32'd1);
        checkOutput("drop_rd_data",  32'(bus1.rd_data),  32'h3C);
        checkOutput("drop_rd_error", 32'(bus1.rd_error), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("keep_second_data", 32'(bus0.rd_data), 32'h3C);
        checkOutput("drop_after_pop",   32'(bus1.empty),   32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("keep_after_pops", 32'(bus0.empty), 32'd1);

        // done held high through reset release, then saturate the error count
        applyStimulus(1'b1, 8'h77, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("held_done_count_keep", 32'(bus0.count), 32'd0);
        checkOutput("held_done_count_drop", 32'(bus1.count), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 254; i++) sendFrame(8'(i), 3'b100, 1'b0, 1'b0);
        checkOutput("err_cnt_254",   32'(bus0.err_cnt), 32'd254);
        checkOutput("err_fill_count", 32'(bus0.count),  32'd16);
        checkOutput("err_overrun",    32'(bus0.overrun), 32'd1);
        for (int i = 0; i < 46; i++) sendFrame(8'(i), 3'b100, 1'b0, 1'b0);
        checkOutput("err_sat_keep",     32'(bus0.err_cnt), 32'd255);
        checkOutput("err_sat_drop",     32'(bus1.err_cnt), 32'd255);
        checkOutput("err_drop_count",   32'(bus1.count),   32'd0);
        checkOutput("err_drop_overrun", 32'(bus1.overrun), 32'd0);

        // interleaved traffic across the pointer wrap against a queue model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_q.delete();
        model_prev_done = 1'b0;
        next_byte = 8'h80;
        for (int c = 0; c < 80; c++) begin
            cyc_done = ((c % 2) == 0);
            cyc_rd   = ((c % 3) == 1);
            applyStimulus(cyc_done, next_byte, 3'b000, cyc_rd, 1'b0);
            if (model_q.size() > 0) begin
                checkOutput($sformatf("mix_data_%0d", c), 32'(bus0.rd_data), 32'(model_q[0]));
            end
            tick();
            model_pop = cyc_rd && (model_q.size() > 0);
            model_wr  = cyc_done && !model_prev_done;
            if (model_wr && ((model_q.size() < 16) || model_pop)) begin
                model_q.push_back(next_byte);
            end
            if (model_pop) void'(model_q.pop_front());
            if (model_wr) next_byte = next_byte + 8'd1;
            model_prev_done = cyc_done;
            checkOutput($sformatf("mix_count_%0d", c), 32'(bus0.count), 32'(model_q.size()));
        end
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("mix_nonempty", 32'(bus0.empty), 32'd0);

        // asynchronous reset clears state without waiting for a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(bus0.count), 32'd0);
        checkOutput("async_rst_empty", 32'(bus0.empty), 32'd1);
        tick();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
